// File: rtl/dl_frame_packer.sv
// -----------------------------------------------------------------------------
// dl_frame_packer
//
// Sits between the delay-line capture register and the uart_tx byte serializer.
// Captured samples are buffered in a small FIFO. Each sample is sent as a framed
// byte stream so the MCU can resynchronise:
//   SYNC_BYTE, [seq], data byte 0 .. DATASIZE/8-1 (LSB first), XOR checksum
// The checksum covers the seq byte (when present) and the data bytes. It does
// not cover SYNC_BYTE. Bytes are paced by the uart_tx tx_dv/tx_done handshake.
//
// Optional feature macro: DL_FRAME_SEQ_EN
//   defined   -> an 8-bit frame sequence number follows SYNC_BYTE; it wraps
//                from 255 to 0 and is part of the checksum.
//   undefined -> no seq byte and no seq register.
//
// Ports
//   clk10m      in   10 MHz system clock; all state changes on its rising edge
//   rst_n       in   synchronous active-low reset
//   smp_valid   in   one-cycle strobe: smp_data holds a new sample
//   smp_data    in   captured delay-line word (DATASIZE bits)
//   tx_dv       out  one-cycle push of tx_byte to uart_tx
//   tx_byte     out  byte for uart_tx; holds its value until the next push
//   tx_done     in   uart_tx one-cycle pulse: byte finished (used only in WAIT)
//   busy        out  high while a frame is in flight
//   fifo_level  out  number of samples currently buffered
//   ovf         out  sticky flag: a sample was dropped because the FIFO was full
//   ovf_clr     in   clears ovf (a drop in the same cycle wins)
// -----------------------------------------------------------------------------
module dl_frame_packer #(
    parameter int         DATASIZE   = 64,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk10m,
    input  logic                          rst_n,
    input  logic                          smp_valid,
    input  logic [DATASIZE-1:0]           smp_data,
    output logic                          tx_dv,
    output logic [7:0]                    tx_byte,
    input  logic                          tx_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int NBYTES = DATASIZE / 8;
`ifdef DL_FRAME_SEQ_EN
    localparam int SEQ_HDR = 1;
`else
    localparam int SEQ_HDR = 0;
`endif
    // Bytes per frame and the frame index of data byte 0.
    localparam int NB   = NBYTES + 2 + SEQ_HDR;
    localparam int DOFF = 1 + SEQ_HDR;
    localparam int IW   = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    // Selects byte k of the sample; a constant-index loop keeps the select
    // within the word without any variable part-select.
    function automatic logic [7:0] data_byte(input logic [DATASIZE-1:0] w,
                                             input logic [IW-1:0]       k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (k == IW'(i)) begin
                b = w[8*i +: 8];
            end
        end
        return b;
    endfunction

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATASIZE-1:0]   mem_q [FIFO_DEPTH];
    logic [DATASIZE-1:0]   mem_d [FIFO_DEPTH];
    logic [DATASIZE-1:0]   shadow_q, shadow_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic                  ovf_q, ovf_d;
    logic                  tx_dv_q, tx_dv_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
`ifdef DL_FRAME_SEQ_EN
    logic [7:0]            seq_q, seq_d;
`endif

    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [7:0]            cur_byte;
    logic                  is_payload;

    // FIFO bookkeeping. A pop in the same cycle frees a slot, so a full FIFO
    // can still accept a sample while the FSM is taking the head.
    always_comb begin
        full     = (count_q == CW'(FIFO_DEPTH));
        push     = smp_valid && (!full || pop);
        drop     = smp_valid && full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) begin
            mem_d[wr_ptr_q] = smp_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        // Clear first so that a drop in the same cycle keeps the flag set.
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Byte at the current frame position and whether it feeds the checksum.
    always_comb begin
        cur_byte   = data_byte(shadow_q, idx_q - IW'(DOFF));
        is_payload = 1'b1;
        if (idx_q == '0) begin
            cur_byte   = SYNC_BYTE;
            is_payload = 1'b0;
        end else if (idx_q == IW'(NB - 1)) begin
            cur_byte   = csum_q;
            is_payload = 1'b0;
        end
`ifdef DL_FRAME_SEQ_EN
        else if (idx_q == IW'(1)) begin
            cur_byte = seq_q;
        end
`endif
    end

    // Frame FSM: IDLE pops a sample, SEND issues one byte, WAIT holds until
    // uart_tx reports the byte finished.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        shadow_d  = shadow_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
`ifdef DL_FRAME_SEQ_EN
        seq_d     = seq_q;
`endif

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    shadow_d = mem_q[rd_ptr_q];
                    idx_d    = '0;
                    csum_d   = 8'h00;
                    state_d  = SEND;
                end
            end
            SEND: begin
                tx_dv_d   = 1'b1;
                tx_byte_d = cur_byte;
                if (is_payload) begin
                    csum_d = csum_q ^ cur_byte;
                end
                state_d   = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (idx_q == IW'(NB - 1)) begin
`ifdef DL_FRAME_SEQ_EN
                        seq_d = seq_q + 8'd1;
`endif
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = SEND;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and outputs; reset abandons any frame in flight.
    always_ff @(posedge clk10m) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
`ifdef DL_FRAME_SEQ_EN
            seq_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
`ifdef DL_FRAME_SEQ_EN
            seq_q     <= seq_d;
`endif
        end
    end

    // Datapath storage; always reloaded before use, so no reset needed.
    always_ff @(posedge clk10m) begin
        mem_q    <= mem_d;
        shadow_q <= shadow_d;
        idx_q    <= idx_d;
        csum_q   <= csum_d;
    end

    assign tx_dv      = tx_dv_q;
    assign tx_byte    = tx_byte_q;
    assign busy       = (state_q != IDLE);
    assign fifo_level = count_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_dl_frame_packer.sv
`timescale 1ns/1ps
module tb_dl_frame_packer;

    localparam int DATASIZE   = 64;
    localparam int FIFO_DEPTH = 4;
`ifdef DL_FRAME_SEQ_EN
    localparam int SEQ_HDR = 1;
`else
    localparam int SEQ_HDR = 0;
`endif
    localparam int NB = DATASIZE / 8 + 2 + SEQ_HDR;

    logic                 clk10m = 1'b0;
    logic                 rst_n;
    logic                 smp_valid;
    logic [DATASIZE-1:0]  smp_data;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_done;
    logic                 busy;
    logic [2:0]           fifo_level;
    logic                 ovf;
    logic                 ovf_clr;

    logic                 tx_done_auto = 1'b0;
    logic                 tx_done_spur;
    assign tx_done = tx_done_auto | tx_done_spur;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    logic [7:0] seq_m;
    bit         auto_en;
    int         done_cnt = 0;
    int         done_pulses = 0;

    dl_frame_packer #(
        .DATASIZE   (DATASIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk10m     (clk10m),
        .rst_n      (rst_n),
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .tx_dv      (tx_dv),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .busy       (busy),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #50 clk10m = ~clk10m;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk10m);
    endtask

    // Reference frame builder: pushes the expected byte stream of one sample.
    task automatic push_model(input logic [DATASIZE-1:0] d);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
`ifdef DL_FRAME_SEQ_EN
        exp_q.push_back(seq_m);
        cs = cs ^ seq_m;
`endif
        for (int k = 0; k < DATASIZE / 8; k++) begin
            b = d[8*k +: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
        seq_m = seq_m + 8'd1;
    endtask

    task automatic drive_sample(input logic [DATASIZE-1:0] d, input bit accepted);
        smp_valid = 1'b1;
        smp_data  = d;
        if (accepted) push_model(d);
        tick();
        smp_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && busy === 1'b0) break;
            tick();
        end
        check_val("drain", 64'(exp_q.size()), 64'd0);
        check_val("idle_busy", 64'(busy), 64'd0);
    endtask

    // Scoreboard: every tx_dv pulse pops one expected byte.
    initial begin
        forever begin
            @(negedge clk10m);
            if (tx_dv === 1'b1) begin
                rx_log.push_back(tx_byte);
                if (exp_q.size() == 0) check_val("extra_byte", 64'(exp_q.size()), 64'd1);
                else check_val("byte", 64'(tx_byte), 64'(exp_q.pop_front()));
            end
        end
    end

    // uart_tx stand-in: tx_done three cycles after each tx_dv.
    initial begin
        forever begin
            @(negedge clk10m);
            tx_done_auto = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    tx_done_auto = 1'b1;
                    done_pulses++;
                end
            end
            if (tx_dv === 1'b1 && auto_en) done_cnt = 3;
        end
    end

    initial begin
        #8_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int base;
        logic [7:0] prev_seq;
        rst_n        = 1'b0;
        smp_valid    = 1'b0;
        smp_data     = '0;
        ovf_clr      = 1'b0;
        tx_done_spur = 1'b0;
        auto_en      = 1'b1;
        seq_m        = 8'h00;
        prev_seq     = 8'h00;
        tick();
        tick();
        check_val("rst_tx_dv", 64'(tx_dv), 64'd0);
        check_val("rst_tx_byte", 64'(tx_byte), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_level", 64'(fifo_level), 64'd0);
        check_val("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        tick();

        // First frame: latency from empty/IDLE and the reference byte vector.
        mark = rx_log.size();
        drive_sample(64'hAA01_2345_AA01_2345, 1'b1);
        check_val("lat_level_n", 64'(fifo_level), 64'd1);
        check_val("lat_busy_n", 64'(busy), 64'd0);
        tick();
        check_val("lat_pop_level", 64'(fifo_level), 64'd0);
        check_val("lat_pop_busy", 64'(busy), 64'd1);
        check_val("lat_pop_dv", 64'(tx_dv), 64'd0);
        tick();
        check_val("lat_dv", 64'(tx_dv), 64'd1);
        check_val("lat_sync", 64'(tx_byte), 64'hA5);
        wait_idle();
        check_val("t1_count", 64'(rx_log.size() - mark), 64'(NB));
        check_val("t1_d0", 64'(rx_log[mark + 1 + SEQ_HDR]), 64'h45);
        check_val("t1_d3", 64'(rx_log[mark + 4 + SEQ_HDR]), 64'hAA);
        check_val("t1_csum", 64'(rx_log[mark + NB - 1]), 64'h00);
`ifdef DL_FRAME_SEQ_EN
        check_val("t1_seq", 64'(rx_log[mark + 1]), 64'h00);
`endif

        // Second frame: single nonzero low byte.
        mark = rx_log.size();
        drive_sample(64'h0000_0000_0000_00FF, 1'b1);
        wait_idle();
        check_val("t2_d0", 64'(rx_log[mark + 1 + SEQ_HDR]), 64'hFF);
        check_val("t2_d1", 64'(rx_log[mark + 2 + SEQ_HDR]), 64'h00);
        check_val("t2_csum", 64'(rx_log[mark + NB - 1]), (SEQ_HDR != 0) ? 64'hFE : 64'hFF);

        // Overflow: uart stalled, six back-to-back samples.
        auto_en = 1'b0;
        mark = rx_log.size();
        for (int i = 0; i < 6; i++) begin
            drive_sample(64'h0101_0101_0101_0101 * 64'(i + 1), i < 5);
        end
        check_val("ovf_set", 64'(ovf), 64'd1);
        check_val("ovf_level", 64'(fifo_level), 64'd4);
        smp_valid = 1'b1;
        smp_data  = 64'hDEAD_BEEF_0000_0007;
        ovf_clr   = 1'b1;
        tick();
        smp_valid = 1'b0;
        ovf_clr   = 1'b0;
        check_val("ovf_set_wins", 64'(ovf), 64'd1);
        check_val("ovf_level2", 64'(fifo_level), 64'd4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_val("ovf_clr", 64'(ovf), 64'd0);
        tx_done_spur = 1'b1;
        tick();
        tx_done_spur = 1'b0;
        auto_en = 1'b1;
        wait_idle();
        check_val("ovf_frames", 64'(rx_log.size() - mark), 64'(5 * NB));

        // Spurious tx_done in IDLE, then in SEND.
        tx_done_spur = 1'b1;
        tick();
        tick();
        tx_done_spur = 1'b0;
        tick();
        check_val("spur_idle_busy", 64'(busy), 64'd0);
        check_val("spur_idle_dv", 64'(tx_dv), 64'd0);
        mark = rx_log.size();
        drive_sample(64'h0123_4567_89AB_CDEF, 1'b1);
        tick();
        check_val("spur_send_busy", 64'(busy), 64'd1);
        tx_done_spur = 1'b1;
        tick();
        tx_done_spur = 1'b0;
        check_val("spur_send_dv", 64'(tx_dv), 64'd1);
        wait_idle();
        check_val("spur_count", 64'(rx_log.size() - mark), 64'(NB));

        // Reset after the third byte's tx_done.
        base = done_pulses;
        drive_sample({$urandom, $urandom}, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (done_pulses >= base + 3) break;
            tick();
        end
        check_val("midrst_reached", 64'(done_pulses >= base + 3), 64'd1);
        rst_n = 1'b0;
        tick();
        check_val("midrst_dv", 64'(tx_dv), 64'd0);
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_level", 64'(fifo_level), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        seq_m = 8'h00;
        for (int i = 0; i < 8; i++) tick();
        check_val("midrst_quiet_dv", 64'(tx_dv), 64'd0);
        check_val("midrst_quiet_busy", 64'(busy), 64'd0);

        // Fresh zero frames after reset.
        for (int f = 0; f < 3; f++) begin
            mark = rx_log.size();
            drive_sample(64'h0, 1'b1);
            wait_idle();
            check_val("zero_sync", 64'(rx_log[mark]), 64'hA5);
`ifdef DL_FRAME_SEQ_EN
            check_val("zero_seq", 64'(rx_log[mark + 1]), 64'(f));
            check_val("zero_csum", 64'(rx_log[mark + NB - 1]), 64'(f));
`else
            check_val("zero_csum", 64'(rx_log[mark + NB - 1]), 64'h00);
`endif
        end

`ifdef DL_FRAME_SEQ_EN
        // Sequence wrap: frame 256 after reset carries seq 00.
        for (int f = 3; f <= 256; f++) begin
            mark = rx_log.size();
            drive_sample({$urandom, $urandom}, 1'b1);
            wait_idle();
            if (f == 255) prev_seq = rx_log[mark + 1];
        end
        check_val("seq_ff", 64'(prev_seq), 64'hFF);
        check_val("seq_wrap", 64'(rx_log[mark + 1]), 64'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
